// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: produces the clock-gate enable level.
// A sleep request is accepted only after the downstream ALU has been idle for
// IDLE_CYCLES consecutive cycles. A wake restores the clock and then spends
// WAKE_CYCLES warm-up cycles before signalling wake_done.
// Runs on the free-running clock. All outputs are registered.
// Optional macro CLK_GATE_CTRL_STATS_EN adds the saturating gated_cycles counter.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              sleep_req,
  input  logic              busy,
  input  logic              wake_req,
  output logic              gate_en,
  output logic              sleep_ack,
  output logic              wake_done,
`ifdef CLK_GATE_CTRL_STATS_EN
  output logic [STAT_W-1:0] gated_cycles,
`endif
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_e;

  // Reject parameter sets the counters cannot represent.
  if (IDLE_CYCLES < 1 || WAKE_CYCLES < 0 || STAT_W < 1 ||
      longint'(IDLE_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(WAKE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $fatal(1, "clk_gate_ctrl: illegal IDLE_CYCLES/WAKE_CYCLES/CNT_W/STAT_W");
  end

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  // A zero-length warm-up never enters WAKE, so this value only matters when WAKE_CYCLES >= 1.
  localparam logic [CNT_W-1:0] WAKE_LAST = (WAKE_CYCLES == 0) ? '0 : CNT_W'(WAKE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             sleep_ack_q, sleep_ack_d;
  logic             wake_done_q, wake_done_d;

  // Next-state logic. The gate outputs are decoded from the next state, so
  // they change on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    wake_done_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (sleep_req) begin
          state_d    = DRAIN;
          idle_cnt_d = '0;
        end
      end
      DRAIN: begin
        // An abort takes priority over finishing the drain.
        if (!sleep_req) begin
          state_d = RUN;
        end else if (busy) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = GATED;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      GATED: begin
        if (wake_req || !sleep_req) begin
          if (WAKE_CYCLES == 0) begin
            state_d     = RUN;
            wake_done_d = 1'b1;
          end else begin
            state_d    = WAKE;
            wake_cnt_d = '0;
          end
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d     = RUN;
          wake_done_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    gate_en_d   = (state_d != GATED);
    sleep_ack_d = (state_d == GATED);
  end

  // State and output registers. Reset re-enables the clock on the reset edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      gate_en_q   <= 1'b1;
      sleep_ack_q <= 1'b0;
      wake_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      gate_en_q   <= gate_en_d;
      sleep_ack_q <= sleep_ack_d;
      wake_done_q <= wake_done_d;
    end
  end

  assign gate_en   = gate_en_q;
  assign sleep_ack = sleep_ack_q;
  assign wake_done = wake_done_q;
  assign state_o   = state_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [STAT_W-1:0] gated_cycles_q, gated_cycles_d;

  // Count edges spent gated. The counter saturates at all-ones and does not wrap.
  always_comb begin
    gated_cycles_d = gated_cycles_q;
    if (state_q == GATED && gated_cycles_q != '1)
      gated_cycles_d = gated_cycles_q + STAT_W'(1);
  end

  // The statistics counter is cleared only by reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) gated_cycles_q <= '0;
    else       gated_cycles_q <= gated_cycles_d;
  end

  assign gated_cycles = gated_cycles_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl. Edge numbers count rising edges after reset release.
// u_dut uses IDLE=4/WAKE=2. u_w0 uses IDLE=1/WAKE=0 and shares the same inputs.
module tb_clk_gate_ctrl;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       sleep_req = 1'b0, busy = 1'b0, wake_req = 1'b0;
  logic       gate_en, sleep_ack, wake_done;
  logic [1:0] state_o;
  logic       z_gate_en, z_sleep_ack, z_wake_done;
  logic [1:0] z_state_o;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [31:0] gated_cycles;
  logic [31:0] z_gated_cycles;
  logic [3:0]  s_gated_cycles;
  logic        s_gate_en, s_sleep_ack, s_wake_done;
  logic [1:0]  s_state_o;
`endif
  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  always #5 CLOCK = ~CLOCK;

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8), .STAT_W(32)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET), .sleep_req(sleep_req), .busy(busy), .wake_req(wake_req),
    .gate_en(gate_en), .sleep_ack(sleep_ack), .wake_done(wake_done),
`ifdef CLK_GATE_CTRL_STATS_EN
    .gated_cycles(gated_cycles),
`endif
    .state_o(state_o));

  clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0), .CNT_W(8), .STAT_W(32)) u_w0 (
    .CLOCK(CLOCK), .RESET(RESET), .sleep_req(sleep_req), .busy(busy), .wake_req(wake_req),
    .gate_en(z_gate_en), .sleep_ack(z_sleep_ack), .wake_done(z_wake_done),
`ifdef CLK_GATE_CTRL_STATS_EN
    .gated_cycles(z_gated_cycles),
`endif
    .state_o(z_state_o));

`ifdef CLK_GATE_CTRL_STATS_EN
  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8), .STAT_W(4)) u_sat (
    .CLOCK(CLOCK), .RESET(RESET), .sleep_req(sleep_req), .busy(busy), .wake_req(wake_req),
    .gate_en(s_gate_en), .sleep_ack(s_sleep_ack), .wake_done(s_wake_done),
    .gated_cycles(s_gated_cycles), .state_o(s_state_o));
`endif

  task automatic tick();
    @(posedge CLOCK);
    ecnt++;
    #1;
  endtask

  task automatic goto(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic rst();
    RESET = 1'b1; sleep_req = 1'b0; busy = 1'b0; wake_req = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    ecnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0h expected %0h", tag, ecnt, obs, exp);
    end
  endtask

  initial begin
    // Basic gate, wake with sleep_req still high, then re-entry into DRAIN.
    rst();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_gate", 32'(gate_en), 1);
    chk("rst_ack", 32'(sleep_ack), 0);
    chk("rst_wdone", 32'(wake_done), 0);
`ifdef CLK_GATE_CTRL_STATS_EN
    chk("rst_stats", gated_cycles, 0);
`endif
    goto(9); sleep_req = 1'b1;
    goto(10);
    chk("a10_state", 32'(state_o), 1);
    chk("a10_gate", 32'(gate_en), 1);
    chk("w0_10_state", 32'(z_state_o), 1);
    goto(11);
    chk("w0_11_gate", 32'(z_gate_en), 0);
    chk("w0_11_state", 32'(z_state_o), 2);
    goto(13);
    chk("a13_gate", 32'(gate_en), 1);
    chk("a13_state", 32'(state_o), 1);
    goto(14);
    chk("a14_gate", 32'(gate_en), 0);
    chk("a14_ack", 32'(sleep_ack), 1);
    chk("a14_state", 32'(state_o), 2);
`ifdef CLK_GATE_CTRL_STATS_EN
    goto(29);
    chk("sat_29", 32'(s_gated_cycles), 15);
`endif
    goto(29); wake_req = 1'b1;
    goto(30);
    chk("a30_gate", 32'(gate_en), 1);
    chk("a30_state", 32'(state_o), 3);
    chk("a30_ack", 32'(sleep_ack), 0);
    chk("w0_30_state", 32'(z_state_o), 0);
    chk("w0_30_wdone", 32'(z_wake_done), 1);
    wake_req = 1'b0;
    goto(31);
    chk("a31_state", 32'(state_o), 3);
    chk("a31_wdone", 32'(wake_done), 0);
    chk("w0_31_state", 32'(z_state_o), 1);
    chk("w0_31_wdone", 32'(z_wake_done), 0);
    goto(32);
    chk("a32_state", 32'(state_o), 0);
    chk("a32_wdone", 32'(wake_done), 1);
    chk("w0_32_state", 32'(z_state_o), 2);
    goto(33);
    chk("a33_wdone", 32'(wake_done), 0);
    chk("a33_state", 32'(state_o), 1);
    sleep_req = 1'b0;
    goto(34);
    chk("a34_state", 32'(state_o), 0);
    chk("w0_34_state", 32'(z_state_o), 0);
    chk("w0_34_wdone", 32'(z_wake_done), 1);

    // Busy restart, then reset while gated.
    rst();
    goto(9); sleep_req = 1'b1;
    goto(11); busy = 1'b1;
    goto(12); busy = 1'b0;
    goto(14);
    chk("b14_gate", 32'(gate_en), 1);
    chk("b14_state", 32'(state_o), 1);
    goto(15);
    chk("b15_gate", 32'(gate_en), 1);
    goto(16);
    chk("b16_gate", 32'(gate_en), 0);
    chk("b16_ack", 32'(sleep_ack), 1);
`ifdef CLK_GATE_CTRL_STATS_EN
    goto(19);
    chk("b19_stats", gated_cycles, 3);
`endif
    goto(19); RESET = 1'b1;
    goto(20);
    chk("r20_gate", 32'(gate_en), 1);
    chk("r20_ack", 32'(sleep_ack), 0);
    chk("r20_state", 32'(state_o), 0);
`ifdef CLK_GATE_CTRL_STATS_EN
    chk("r20_stats", gated_cycles, 0);
`endif
    RESET = 1'b0;

    // Abort during DRAIN. wake_req must be ignored there.
    rst();
    goto(9); sleep_req = 1'b1; wake_req = 1'b1;
    goto(12); sleep_req = 1'b0;
    for (int e = 10; e <= 13; e++) begin
      goto(e);
      chk("c_gate", 32'(gate_en), 1);
      chk("c_wdone", 32'(wake_done), 0);
    end
    chk("c13_state", 32'(state_o), 0);
    wake_req = 1'b0;

    // wake_req and sleep_req drop on the same edge: a single WAKE transition.
    rst();
    goto(9); sleep_req = 1'b1;
    goto(19); wake_req = 1'b1; sleep_req = 1'b0;
    goto(20);
    chk("d20_state", 32'(state_o), 3);
    wake_req = 1'b0;
    goto(21);
    chk("d21_state", 32'(state_o), 3);
    goto(22);
    chk("d22_state", 32'(state_o), 0);
    chk("d22_wdone", 32'(wake_done), 1);

`ifdef CLK_GATE_CTRL_STATS_EN
    // Long gate: 100 edges spent in GATED, plus saturation of the 4-bit counter.
    rst();
    goto(9); sleep_req = 1'b1;
    goto(114);
    chk("e_stats100", gated_cycles, 100);
    chk("e_sat", 32'(s_gated_cycles), 15);
    sleep_req = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
